// File: rtl/goomba_sprite_fetch.sv
// rtl/goomba_sprite_fetch.sv - Goomba sprite ROM address/pixel pipeline with walk animation and stomp life cycle
// Two-stage fetch: hit test -> ROM address, then ROM colour -> keyed pixel.
module goomba_sprite_fetch #(
    parameter int          SPR_W         = 20,
    parameter int          SPR_H         = 22,
    parameter int          ANIM_FRAMES   = 8,
    parameter int          SQUASH_FRAMES = 30,
    parameter logic [11:0] TRANSPARENT   = 12'h808
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  goomba_x,
    input  logic [9:0]  goomba_y,
    input  logic        dir_left,
    input  logic        stomp,
    input  logic        respawn,
    output logic [8:0]  read_address,
    output logic        walk_sel,
    input  logic [11:0] rom_color_1,
    input  logic [11:0] rom_color_2,
    output logic        pixel_on,
    output logic [11:0] pixel_color,
    output logic        gone
);
    localparam int AW = $clog2(ANIM_FRAMES);
    localparam int SW = $clog2(SQUASH_FRAMES);

    typedef enum logic [1:0] {WALK, SQUASH, GONE} state_t;

    state_t        state_q;
    logic [AW-1:0] anim_q;
    logic [SW-1:0] squash_q;
    logic          walk_sel_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= WALK;
            anim_q     <= '0;
            squash_q   <= '0;
            walk_sel_q <= 1'b0;
        end else if (respawn) begin
            state_q    <= WALK;
            anim_q     <= '0;
            walk_sel_q <= 1'b0;
        end else begin
            case (state_q)
                WALK: begin
                    if (stomp) begin
                        state_q    <= SQUASH;
                        squash_q   <= '0;
                        walk_sel_q <= 1'b0;
                    end else if (frame_start) begin
                        if (anim_q == AW'(ANIM_FRAMES - 1)) begin
                            anim_q     <= '0;
                            walk_sel_q <= ~walk_sel_q;
                        end else begin
                            anim_q <= anim_q + 1'b1;
                        end
                    end
                end
                SQUASH: begin
                    if (frame_start) begin
                        if (squash_q == SW'(SQUASH_FRAMES - 1))
                            state_q <= GONE;
                        else
                            squash_q <= squash_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Offsets wrap, so pixels left of / above the box become large and miss.
    logic [9:0] dx, dy;
    logic       hit_d;
    logic [8:0] row_d, col_d, addr_d;

    always_comb begin
        dx     = DrawX - goomba_x;
        dy     = DrawY - goomba_y;
        hit_d  = 1'b0;
        row_d  = '0;
        case (state_q)
            WALK: begin
                hit_d = (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));
                row_d = 9'(dy);
            end
            SQUASH: begin
                // Lower half of the box shows every other ROM row: a flattened sprite.
                hit_d = (dx < 10'(SPR_W)) && (dy >= 10'(SPR_H / 2)) && (dy < 10'(SPR_H));
                row_d = 9'({dy - 10'(SPR_H / 2), 1'b0});
            end
            default: ;
        endcase
        col_d  = dir_left ? 9'(dx) : 9'(10'(SPR_W - 1) - dx);
        addr_d = hit_d ? (row_d * 9'(SPR_W) + col_d) : '0;
    end

    logic [8:0] read_address_q;
    logic       hit_d1_q;
    logic       walk_sel_d1_q;
    logic       pixel_on_q;
    logic [11:0] pixel_color_q;
    logic [11:0] color_d;

    assign color_d = walk_sel_d1_q ? rom_color_2 : rom_color_1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            read_address_q <= '0;
            hit_d1_q       <= 1'b0;
            walk_sel_d1_q  <= 1'b0;
            pixel_on_q     <= 1'b0;
            pixel_color_q  <= '0;
        end else begin
            read_address_q <= addr_d;
            hit_d1_q       <= hit_d;
            walk_sel_d1_q  <= walk_sel_q;
            pixel_on_q     <= hit_d1_q && (color_d != TRANSPARENT);
            pixel_color_q  <= (hit_d1_q && (color_d != TRANSPARENT)) ? color_d : 12'h000;
        end
    end

    assign read_address = read_address_q;
    assign walk_sel     = walk_sel_q;
    assign pixel_on     = pixel_on_q;
    assign pixel_color  = pixel_color_q;
    assign gone         = (state_q == GONE);
endmodule

// File: tb/tb_goomba_sprite_fetch.sv
// tb/tb_goomba_sprite_fetch.sv - directed self-checking bench for goomba_sprite_fetch
module tb_goomba_sprite_fetch;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, goomba_x = '0, goomba_y = '0;
    logic        dir_left = 1'b1, stomp = 1'b0, respawn = 1'b0;
    logic [8:0]  read_address;
    logic        walk_sel, pixel_on, gone;
    logic [11:0] rom_color_1, rom_color_2, pixel_color;

    int n_cmp = 0;
    int n_bad = 0;

    goomba_sprite_fetch dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .goomba_x(goomba_x), .goomba_y(goomba_y),
        .dir_left(dir_left), .stomp(stomp), .respawn(respawn),
        .read_address(read_address), .walk_sel(walk_sel),
        .rom_color_1(rom_color_1), .rom_color_2(rom_color_2),
        .pixel_on(pixel_on), .pixel_color(pixel_color), .gone(gone)
    );

    always #5 Clk = ~Clk;

    // ROM models: walk_1 has a transparent texel at 5 and a known colour at 6.
    assign rom_color_1 = (read_address == 9'd5) ? 12'h808 :
                         (read_address == 9'd6) ? 12'hE51 : {3'b001, read_address};
    assign rom_color_2 = {3'b011, read_address};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
        end
    endtask

    // Present a coordinate, check address after one cycle and pixel after two.
    task automatic probe(input string tag, input int x, input int y,
                         input logic [8:0] exp_addr, input logic exp_on, input logic [11:0] exp_col);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step();
        check({tag, " addr"}, 32'(read_address), 32'(exp_addr));
        step();
        check({tag, " on"}, 32'(pixel_on), 32'(exp_on));
        check({tag, " color"}, 32'(pixel_color), 32'(exp_col));
    endtask

    initial begin
        step();
        step();
        check("rst addr", 32'(read_address), 32'd0);
        check("rst walk_sel", 32'(walk_sel), 32'd0);
        check("rst on", 32'(pixel_on), 32'd0);
        check("rst color", 32'(pixel_color), 32'd0);
        check("rst gone", 32'(gone), 32'd0);
        Reset = 1'b0;
        goomba_x = 10'd100;
        goomba_y = 10'd200;
        dir_left = 1'b1;

        for (int i = 0; i < 20; i++)
            if (i != 5 && i != 6)
                probe("row5 scan", 100 + i, 205, 9'(100 + i), 1'b1, {3'b001, 9'(100 + i)});
        probe("left miss", 99, 205, 9'd0, 1'b0, 12'h000);
        probe("right miss", 120, 205, 9'd0, 1'b0, 12'h000);
        probe("above miss", 100, 199, 9'd0, 1'b0, 12'h000);
        probe("below miss", 100, 222, 9'd0, 1'b0, 12'h000);
        probe("last texel", 119, 221, 9'd439, 1'b1, {3'b001, 9'd439});

        dir_left = 1'b0;
        probe("mirror left", 100, 200, 9'd19, 1'b1, {3'b001, 9'd19});
        probe("mirror right", 119, 200, 9'd0, 1'b1, 12'h200);
        dir_left = 1'b1;

        probe("transparent", 105, 200, 9'd5, 1'b0, 12'h000);
        probe("opaque E51", 106, 200, 9'd6, 1'b1, 12'hE51);

        pulse_frames(7);
        check("walk_sel after 7", 32'(walk_sel), 32'd0);
        pulse_frames(1);
        check("walk_sel after 8", 32'(walk_sel), 32'd1);
        probe("rom2 select", 100, 205, 9'd100, 1'b1, {3'b011, 9'd100});
        pulse_frames(8);
        check("walk_sel after 16", 32'(walk_sel), 32'd0);
        probe("rom1 again", 100, 205, 9'd100, 1'b1, {3'b001, 9'd100});
        pulse_frames(8);
        check("walk_sel after 24", 32'(walk_sel), 32'd1);

        stomp = 1'b1;
        step();
        stomp = 1'b0;
        check("squash walk_sel", 32'(walk_sel), 32'd0);
        probe("squash top miss", 100, 210, 9'd0, 1'b0, 12'h000);
        probe("squash first row", 100, 211, 9'd0, 1'b1, 12'h200);
        probe("squash floor", 100, 221, 9'd400, 1'b1, {3'b001, 9'd400});
        pulse_frames(8);
        check("squash holds anim", 32'(walk_sel), 32'd0);
        pulse_frames(21);
        check("gone after 29", 32'(gone), 32'd0);
        pulse_frames(1);
        check("gone after 30", 32'(gone), 32'd1);
        probe("gone no pixel", 105, 215, 9'd0, 1'b0, 12'h000);
        probe("gone no pixel 2", 100, 221, 9'd0, 1'b0, 12'h000);

        respawn = 1'b1;
        step();
        respawn = 1'b0;
        check("respawn gone", 32'(gone), 32'd0);
        probe("respawn walk", 100, 205, 9'd100, 1'b1, {3'b001, 9'd100});

        stomp = 1'b1;
        respawn = 1'b1;
        step();
        stomp = 1'b0;
        respawn = 1'b0;
        probe("stomp+respawn walk", 101, 205, 9'd101, 1'b1, {3'b001, 9'd101});

        stomp = 1'b1;
        step();
        stomp = 1'b0;
        probe("pre-reset squash", 100, 215, 9'd160, 1'b1, {3'b001, 9'd160});
        check("pre-reset addr live", 32'(read_address), 32'd160);
        #2;
        Reset = 1'b1;
        #1;
        check("async rst addr", 32'(read_address), 32'd0);
        check("async rst on", 32'(pixel_on), 32'd0);
        check("async rst color", 32'(pixel_color), 32'd0);
        check("async rst walk_sel", 32'(walk_sel), 32'd0);
        check("async rst gone", 32'(gone), 32'd0);
        step();
        Reset = 1'b0;
        probe("post-reset walk", 100, 205, 9'd100, 1'b1, {3'b001, 9'd100});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
